pht_ctrl: RTL and testbench
===========================

Name: pht_ctrl

Overview:
Controller for the branch Pattern History Table (PHT) that supplies the 2-bit prediction used by the IF-stage next-PC mux select logic. Owns the table of 2-bit saturating counters, gshare-style index formation, post-reset table initialisation sweep, resolution-time counter/history update and prediction statistics. Sits beside the IF stage (lookup) and the ID stage (branch resolution/update).

Parameters:
IDX_W, 6, table index width; table depth = 2**IDX_W entries
GHR_W, 4, global history length; 0 = plain bimodal (no history XOR); legal 0..IDX_W
INIT_STATE, 2'b01, counter value written by the init sweep (weakly not taken)
STAT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
CE  in  1  pipeline enable; 0 = stall
lookup_pc  in  32  IF-stage PC
pht_out  out  2  predicted counter for lookup_pc (bit1 = predict taken)
lookup_idx  out  IDX_W  index used for this lookup; carried down the pipe to upd_idx
upd_valid  in  1  a conditional branch resolved this cycle
upd_idx  in  IDX_W  index captured at lookup time for that branch
upd_taken  in  1  actual outcome
upd_mispredict  in  1  prediction was wrong (flush issued)
init_busy  out  1  init sweep in progress
ghr_out  out  max(GHR_W,1)  current global history (0 when GHR_W=0)
br_cnt  out  STAT_W  resolved-branch count
mis_cnt  out  STAT_W  mispredict count
stat_clr  in  1  synchronous clear of both statistics counters

Behaviour:
- Reset (rst=0, async): FSM -> INIT, sweep pointer = 0, GHR = 0, br_cnt = mis_cnt = 0, init_busy = 1. Table contents undefined until swept.
- FSM states INIT, RUN. INIT: each clk writes INIT_STATE to entry[ptr], ptr++; ignores CE. After writing entry 2**IDX_W-1 -> RUN next cycle; init_busy = 1 for exactly 2**IDX_W cycles after reset release. RUN is terminal until next reset.
- During INIT: pht_out = INIT_STATE, upd_valid ignored (no write, no GHR shift, no stats), lookup_idx still computed.
- Index: lookup_idx = lookup_pc[IDX_W+1:2] XOR zero-extended GHR (GHR_W=0: no XOR). Combinational.
- pht_out combinational read of entry[lookup_idx]. Bypass: if RUN & CE & upd_valid & upd_idx==lookup_idx, pht_out = the value being written this edge.
- Update (RUN & CE & upd_valid), on rising edge: entry[upd_idx] <= sat(entry, upd_taken): taken increments, saturates at 2'b11; not-taken decrements, saturates at 2'b00. GHR <= {GHR[GHR_W-2:0], upd_taken} (non-speculative; resolution only).
- Stats (RUN & CE & upd_valid): br_cnt +1; mis_cnt +1 if upd_mispredict. Both saturate at all-ones, no wrap. stat_clr=1 clears both regardless of CE/state; clear wins over same-cycle increment.
- CE=0 in RUN: no table write, no GHR shift, no stat increment; outputs still track lookup_pc.
- rst asserted mid-sweep or mid-RUN: immediate return to reset values; sweep restarts from 0.

Decomposition:
- Package pht_pkg: counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11; FSM enum {INIT, RUN}; branch opcode constant 7'b1100011.
- Sub-module pht_sat2: 2-bit saturating next-state (cur, taken -> next), reused for update and bypass paths.

Test Plan:
- Release rst with IDX_W=6 -> init_busy high exactly 64 cycles; then lookup any PC -> pht_out=2'b01; upd_valid during sweep leaves br_cnt=0.
- GHR_W=0, three taken updates to upd_idx=5 -> entry 5: 01->10->11->11; lookup_pc=0x14 -> pht_out=2'b11; four not-taken -> 00, stays 00.
- Same cycle lookup_pc=0x14 (idx 5, entry=01) and upd_idx=5 taken -> pht_out=2'b10 that cycle; next cycle 2'b10 from table.
- GHR_W=4: updates taken,taken,not,taken -> ghr_out=4'b1101; lookup_pc=0x14 -> lookup_idx=6'b001000.
- 10 updates, 3 with upd_mispredict, one during CE=0 -> br_cnt=9 (if stalled one was mispredict, mis_cnt=2); stat_clr with concurrent upd_valid -> both 0 next cycle; preload near max -> saturates at 0xFFFF.
- Assert rst at sweep cycle 30 -> outputs reset immediately; after release init_busy again 64 cycles.

Source files
------------

// File: rtl/pht_pkg.sv
// Shared encodings for the branch pattern history table controller:
// 2-bit counter states, controller FSM states and the branch opcode.
package pht_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    INIT,
    RUN
  } pht_state_e;

endpackage

// File: rtl/pht_sat2.sv
// 2-bit saturating counter next-state: taken counts up to ST, not-taken
// counts down to SNT.
module pht_sat2
  import pht_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       taken_i,
  output logic [1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    if (taken_i) begin
      if (cur_i != ST) next_o = cur_i + 2'd1;
    end else begin
      if (cur_i != SNT) next_o = cur_i - 2'd1;
    end
  end

endmodule

// File: rtl/pht_ctrl.sv
// Pattern history table controller: gshare lookup for IF, resolution-time
// counter/history update from ID, post-reset init sweep and branch statistics.
module pht_ctrl
  import pht_pkg::*;
#(
  parameter int         IDX_W      = 6,
  parameter int         GHR_W      = 4,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         STAT_W     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                CE,
  input  logic [31:0]                         lookup_pc,
  output logic [1:0]                          pht_out,
  output logic [IDX_W-1:0]                    lookup_idx,
  input  logic                                upd_valid,
  input  logic [IDX_W-1:0]                    upd_idx,
  input  logic                                upd_taken,
  input  logic                                upd_mispredict,
  output logic                                init_busy,
  output logic [((GHR_W > 0) ? GHR_W : 1)-1:0] ghr_out,
  output logic [STAT_W-1:0]                   br_cnt,
  output logic [STAT_W-1:0]                   mis_cnt,
  input  logic                                stat_clr
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int GW    = (GHR_W > 0) ? GHR_W : 1;

  pht_state_e        state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic              busy_q;
  logic [GW-1:0]     ghr_q;
  logic [GW-1:0]     ghr_d;
  logic [STAT_W-1:0] br_q;
  logic [STAT_W-1:0] mis_q;

  logic [1:0]        pht_mem [DEPTH];
  logic [IDX_W-1:0]  ghr_ext;
  logic [1:0]        upd_cur;
  logic [1:0]        upd_next;
  logic              upd_en;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

  assign upd_en = (state_q == RUN) && CE && upd_valid;

  // History shifts in the resolved outcome; with no history it stays zero.
  generate
    if (GHR_W == 0) begin : g_no_ghr
      assign ghr_d = '0;
    end else if (GHR_W == 1) begin : g_ghr1
      assign ghr_d = upd_taken;
    end else begin : g_ghrn
      assign ghr_d = {ghr_q[GW-2:0], upd_taken};
    end
  endgenerate

  always_comb begin
    ghr_ext         = '0;
    ghr_ext[GW-1:0] = ghr_q;
  end

  assign lookup_idx = lookup_pc[IDX_W+1:2] ^ ghr_ext;

  assign upd_cur = pht_mem[upd_idx];

  pht_sat2 u_sat (
    .cur_i   (upd_cur),
    .taken_i (upd_taken),
    .next_o  (upd_next)
  );

  // A lookup hitting the entry being written this edge sees the new value.
  always_comb begin
    pht_out = pht_mem[lookup_idx];
    if (state_q == INIT) begin
      pht_out = INIT_STATE;
    end else if (upd_en && (upd_idx == lookup_idx)) begin
      pht_out = upd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      pht_mem[ptr_q] <= INIT_STATE;
    end else if (upd_en) begin
      pht_mem[upd_idx] <= upd_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      ghr_q   <= '0;
      br_q    <= '0;
      mis_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          ptr_q <= ptr_q + IDX_W'(1);
          if (ptr_q == IDX_W'(DEPTH - 1)) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (upd_en) ghr_q <= ghr_d;
        end
        default: state_q <= INIT;
      endcase

      // Clear takes priority over an increment in the same cycle.
      if (stat_clr) begin
        br_q  <= '0;
        mis_q <= '0;
      end else if (upd_en) begin
        if (br_q != {STAT_W{1'b1}}) br_q <= br_q + STAT_W'(1);
        if (upd_mispredict && (mis_q != {STAT_W{1'b1}})) mis_q <= mis_q + STAT_W'(1);
      end
    end
  end

  assign init_busy = busy_q;
  assign ghr_out   = ghr_q;
  assign br_cnt    = br_q;
  assign mis_cnt   = mis_q;

endmodule

// File: tb/tb_pht_ctrl.sv
// Directed bench for pht_ctrl: a bimodal instance and a gshare instance with
// narrow statistics counters share one stimulus stream.
module tb_pht_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        CE = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0;
  logic [5:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic        stat_clr = 1'b0;

  logic [1:0]  b_pht, g_pht;
  logic [5:0]  b_idx, g_idx;
  logic        b_busy, g_busy;
  logic        b_ghr;
  logic [3:0]  g_ghr;
  logic [15:0] b_br, b_mis;
  logic [3:0]  g_br, g_mis;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pht_ctrl #(.IDX_W(6), .GHR_W(0), .INIT_STATE(2'b01), .STAT_W(16)) u_bim (
    .clk(clk), .rst(rst), .CE(CE), .lookup_pc(lookup_pc),
    .pht_out(b_pht), .lookup_idx(b_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .init_busy(b_busy), .ghr_out(b_ghr),
    .br_cnt(b_br), .mis_cnt(b_mis), .stat_clr(stat_clr)
  );

  pht_ctrl #(.IDX_W(6), .GHR_W(4), .INIT_STATE(2'b01), .STAT_W(4)) u_gsh (
    .clk(clk), .rst(rst), .CE(CE), .lookup_pc(lookup_pc),
    .pht_out(g_pht), .lookup_idx(g_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .init_busy(g_busy), .ghr_out(g_ghr),
    .br_cnt(g_br), .mis_cnt(g_mis), .stat_clr(stat_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [5:0] idx, input logic t, input logic m, input logic ce);
    upd_valid = 1'b1;
    upd_idx = idx;
    upd_taken = t;
    upd_mispredict = m;
    CE = ce;
    tick();
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    CE = 1'b1;
    #1;
  endtask

  // Counts edges from reset release until init_busy drops (bounded).
  task automatic sweep(input string tag);
    int n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (!g_busy) break;
    end
    check({tag, "_busy_len"}, n, 64);
    check({tag, "_bim_busy"}, b_busy, 0);
  endtask

  initial begin
    logic [1:0] exp_up [3];
    logic [1:0] exp_dn [4];
    logic [3:0] exp_ghr [4];
    logic       pat_t [4];
    exp_up  = '{2'b10, 2'b11, 2'b11};
    exp_dn  = '{2'b10, 2'b01, 2'b00, 2'b00};
    exp_ghr = '{4'b0001, 4'b0011, 4'b0110, 4'b1101};
    pat_t   = '{1'b1, 1'b1, 1'b0, 1'b1};

    repeat (3) tick();
    check("rst_busy", g_busy, 1);
    check("rst_br", b_br, 0);
    check("rst_mis", b_mis, 0);
    check("rst_ghr", g_ghr, 0);

    // Sweep with updates requested throughout; they must be ignored.
    rst = 1'b1;
    upd_valid = 1'b1;
    upd_mispredict = 1'b1;
    upd_idx = 6'd16;
    lookup_pc = 32'h40;
    repeat (30) tick();
    check("sweep30_busy", g_busy, 1);
    check("sweep30_pht", b_pht, 2'b01);
    check("sweep30_idx", b_idx, 16);
    check("sweep30_br", g_br, 0);
    #2;
    rst = 1'b0;
    #1;
    check("midsweep_rst_busy", g_busy, 1);
    repeat (2) tick();
    rst = 1'b1;
    sweep("init");
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    #1;
    check("init_br", b_br, 0);
    check("init_mis", b_mis, 0);
    lookup_pc = 32'h1234;
    #1;
    check("init_pht", b_pht, 2'b01);

    // Bimodal saturating counter at entry 5 (pc 0x14).
    lookup_pc = 32'h14;
    for (int i = 0; i < 3; i++) begin
      upd(6'd5, 1'b1, 1'b0, 1'b1);
      check($sformatf("sat_up%0d", i), b_pht, exp_up[i]);
    end
    for (int i = 0; i < 4; i++) begin
      upd(6'd5, 1'b0, 1'b0, 1'b1);
      check($sformatf("sat_dn%0d", i), b_pht, exp_dn[i]);
    end
    upd(6'd5, 1'b1, 1'b0, 1'b1);
    check("pre_byp", b_pht, 2'b01);

    // Same-cycle lookup and update of entry 5.
    upd_valid = 1'b1;
    upd_idx = 6'd5;
    upd_taken = 1'b1;
    #1;
    check("byp_idx", b_idx, 5);
    check("byp_pht", b_pht, 2'b10);
    tick();
    upd_valid = 1'b0;
    #1;
    check("byp_after", b_pht, 2'b10);

    // Statistics: 10 updates, 3 mispredicts, update 5 stalled (mispredict).
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    check("clr_br", b_br, 0);
    for (int i = 0; i < 10; i++) begin
      upd((i == 5) ? 6'd7 : 6'd9, i[0], (i == 2) || (i == 5) || (i == 7), i != 5);
    end
    check("stat_br", b_br, 9);
    check("stat_mis", b_mis, 2);
    check("bim_ghr", b_ghr, 0);
    lookup_pc = 32'h1C;
    #1;
    check("stall_nowrite", b_pht, 2'b01);
    stat_clr = 1'b1;
    upd(6'd9, 1'b1, 1'b1, 1'b1);
    stat_clr = 1'b0;
    check("clr_win_br", b_br, 0);
    check("clr_win_mis", b_mis, 0);

    // Gshare history after a fresh reset.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sweep("reinit");
    for (int i = 0; i < 4; i++) begin
      upd(6'd3, pat_t[i], 1'b0, 1'b1);
      check($sformatf("ghr%0d", i), g_ghr, exp_ghr[i]);
    end
    lookup_pc = 32'h14;
    #1;
    check("gsh_idx", g_idx, 6'b001000);
    check("bim_idx", b_idx, 6'b000101);
    check("gsh_br4", g_br, 4);

    // Narrow counters saturate instead of wrapping.
    for (int i = 0; i < 16; i++) upd(6'd3, 1'b1, 1'b1, 1'b1);
    check("sat_br", g_br, 4'hF);
    check("sat_mis", g_mis, 4'hF);

    // Asynchronous reset mid-RUN, between clock edges.
    #2;
    rst = 1'b0;
    #1;
    check("async_ghr", g_ghr, 0);
    check("async_br", g_br, 0);
    check("async_mis", g_mis, 0);
    check("async_busy", g_busy, 1);
    tick();
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
